tg_flow_sched: RTL
==================

TG_FLOW_SCHED -- requirements
Module: tg_flow_sched

Interface
REQ-001 Parameter: NUM_FLOWS, default 4, number of traffic-generator flows sharing one C2H stream.
REQ-002 Parameter: BURST_BYTES, default 3000, per-flow credit cap in bytes.
REQ-003 Parameter: CREDIT_W, default 32, credit counter width (8 fractional bits).
REQ-004 user_clk  input  1  single block clock.
REQ-005 user_resetn  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  global scheduler enable.
REQ-007 flow_en  input  NUM_FLOWS  per-flow enable.
REQ-008 rate_inc  input  NUM_FLOWS*16  per-flow credit added per cycle, units 1/256 byte.
REQ-009 frame_len  input  NUM_FLOWS*16  per-flow frame length in bytes, header and CRC included.
REQ-010 req  input  NUM_FLOWS  flow i has a frame ready.
REQ-011 frame_done  input  1  single-cycle pulse from the granted generator on its last beat.
REQ-012 gnt  output  NUM_FLOWS  one-hot grant.
REQ-013 gnt_id  output  clog2(NUM_FLOWS)  index of the granted flow.
REQ-014 gnt_valid  output  1  a grant is active.
REQ-015 frame_cnt  output  32  total frames completed, wraps.
REQ-016 cfg_err  output  NUM_FLOWS  frame_len is 0 or exceeds BURST_BYTES.
REQ-017 proto_err  output  1  sticky; frame_done seen with gnt_valid=0.

Function
REQ-018 Per-flow credit: each cycle credit += rate_inc[i] while flow_en[i]=1; saturate at BURST_BYTES*256; hold at 0 while flow_en[i]=0.
REQ-019 Eligible[i] = req[i] & flow_en[i] & ~cfg_err[i] & (credit[i] >= frame_len[i]*256).
REQ-020 FSM states IDLE, ARB, GRANT; IDLE->ARB when enable=1; ARB->GRANT when any flow is eligible; GRANT->ARB on frame_done when enable=1, else ->IDLE.
REQ-021 ARB picks round-robin, scanning from last granted index+1 with wrap; first pick after reset scans from index 0.
REQ-022 gnt, gnt_id and gnt_valid are registered; they assert the cycle after the ARB decision and hold stable through GRANT.
REQ-023 On the grant cycle: credit[i] <= sat(credit[i] + rate_inc[i] - frame_len[i]*256), with increment and deduction applied in the same cycle.
REQ-024 frame_done in GRANT: gnt_valid deasserts next cycle and frame_cnt increments; the next grant comes no earlier than 2 cycles after frame_done.
REQ-025 Deasserting enable or flow_en of the granted flow mid-frame does not revoke the grant; the grant ends only on frame_done.
REQ-026 Deasserting req of the granted flow mid-frame is ignored.
REQ-027 cfg_err is combinational from frame_len; flows with cfg_err set are never eligible.
REQ-028 frame_done outside GRANT sets proto_err and changes no other state.
REQ-029 Credit arithmetic is done at CREDIT_W+1 bits, then saturated; it never wraps.

Reset
REQ-030 While user_resetn=0: state IDLE, all credits 0, gnt=0, gnt_id=0, gnt_valid=0, frame_cnt=0, proto_err=0, round-robin pointer = NUM_FLOWS-1.
REQ-031 Reset asserted mid-grant drops the grant immediately; no frame_cnt increment.

Structure
REQ-032 Package tg_pkg holds the state enum, CREDIT_FRAC=8, MAX_ETH_FRAME=1500 and ETH_OVERHEAD=18.
REQ-033 Sub-module tg_rr_arbiter (eligible vector and pointer in, one-hot grant and index out, combinational) holds the round-robin selection.

Verification
REQ-034 Single flow: rate_inc=256, frame_len=64, req held -> first gnt 65 cycles after enable; consecutive grants every 64 cycles of credit.
REQ-035 Four flows, all eligible, frame_done 10 cycles after each grant -> grant order 0,1,2,3,0; gnt_valid low exactly 1 cycle between grants.
REQ-036 rate_inc=0xFFFF for 1000 cycles -> credit holds at 3000*256 with no wrap; frame_len=3001 -> cfg_err set and flow never granted.
REQ-037 enable dropped 3 cycles into a grant -> grant held until frame_done, then IDLE; frame_cnt +1.
REQ-038 frame_done pulsed in IDLE -> proto_err=1, frame_cnt unchanged; reset mid-grant -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/tg_pkg.sv
// Shared types and constants for the traffic-generator flow scheduler.
// Credits are fixed point with CREDIT_FRAC fractional bits (1/256 byte units).
package tg_pkg;

  localparam int CREDIT_FRAC   = 8;
  localparam int MAX_ETH_FRAME = 1500;
  localparam int ETH_OVERHEAD  = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2
  } tg_state_e;

endpackage

// File: rtl/tg_rr_arbiter.sv
// Combinational round-robin pick: scans from ptr_i+1 upward with wrap and
// returns the first eligible flow as a one-hot vector plus its index.
module tg_rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   elig_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  logic [IDW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(ptr_i) + k) % N);
      if (!any_o && elig_i[cand]) begin
        any_o        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
  end

endmodule

// File: rtl/tg_flow_sched.sv
// Credit-based scheduler granting one traffic-generator flow at a time onto
// a shared C2H stream; a grant lasts from the ARB decision until frame_done.
module tg_flow_sched
  import tg_pkg::*;
#(
  parameter  int NUM_FLOWS   = 4,
  parameter  int BURST_BYTES = 3000,
  parameter  int CREDIT_W    = 32,
  localparam int IDW         = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1
) (
  input  logic                    user_clk,
  input  logic                    user_resetn,
  input  logic                    enable,
  input  logic [NUM_FLOWS-1:0]    flow_en,
  input  logic [NUM_FLOWS*16-1:0] rate_inc,
  input  logic [NUM_FLOWS*16-1:0] frame_len,
  input  logic [NUM_FLOWS-1:0]    req,
  input  logic                    frame_done,
  output logic [NUM_FLOWS-1:0]    gnt,
  output logic [IDW-1:0]          gnt_id,
  output logic                    gnt_valid,
  output logic [31:0]             frame_cnt,
  output logic [NUM_FLOWS-1:0]    cfg_err,
  output logic                    proto_err,
  output tg_state_e               dbg_state
);

  // Handshake: a flow raises req when a frame is ready; gnt/gnt_valid hold
  // from the cycle after the ARB pick until the cycle after frame_done, which
  // the granted generator pulses on its last beat. req is not sampled again
  // until the next ARB pick, so dropping it mid-frame has no effect.

  localparam logic [CREDIT_W:0] CAP       = (CREDIT_W+1)'(BURST_BYTES) << CREDIT_FRAC;
  localparam logic [15:0]       BURST_LEN = 16'(BURST_BYTES);

  tg_state_e             state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q [NUM_FLOWS];
  logic [CREDIT_W-1:0]   credit_d [NUM_FLOWS];
  logic [NUM_FLOWS-1:0]  gnt_q;
  logic [IDW-1:0]        gnt_id_q;
  logic                  gnt_valid_q;
  logic [31:0]           frame_cnt_q;
  logic                  proto_err_q;
  logic [IDW-1:0]        rr_ptr_q;

  logic [NUM_FLOWS-1:0]  elig;
  logic [NUM_FLOWS-1:0]  arb_gnt;
  logic [IDW-1:0]        arb_idx;
  logic                  arb_any;
  logic                  take_grant;
  logic [CREDIT_W:0]     len_fx [NUM_FLOWS];

  always_comb begin
    cfg_err = '0;
    elig    = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      len_fx[i]  = (CREDIT_W+1)'(frame_len[i*16 +: 16]) << CREDIT_FRAC;
      cfg_err[i] = (frame_len[i*16 +: 16] == 16'd0) || (frame_len[i*16 +: 16] > BURST_LEN);
      elig[i]    = req[i] & flow_en[i] & ~cfg_err[i] & ({1'b0, credit_q[i]} >= len_fx[i]);
    end
  end

  tg_rr_arbiter #(.N(NUM_FLOWS), .IDW(IDW)) u_arb (
    .elig_i (elig),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  assign take_grant = (state_q == ST_ARB) && enable && arb_any;

  // Increment and deduction land in the same cycle; the sum is one bit wider
  // than the counter so the clamp to CAP sees any overflow instead of a wrap.
  always_comb begin
    logic [CREDIT_W:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      sum = {1'b0, credit_q[i]} + (CREDIT_W+1)'(rate_inc[i*16 +: 16]);
      if (take_grant && arb_gnt[i]) sum = sum - len_fx[i];
      credit_d[i] = (sum > CAP) ? CAP[CREDIT_W-1:0] : sum[CREDIT_W-1:0];
      if (!flow_en[i]) credit_d[i] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_ARB;
      ST_ARB: begin
        if (!enable)     state_d = ST_IDLE;
        else if (arb_any) state_d = ST_GRANT;
      end
      ST_GRANT: if (frame_done) state_d = enable ? ST_ARB : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      frame_cnt_q <= '0;
      proto_err_q <= 1'b0;
      rr_ptr_q    <= IDW'(NUM_FLOWS - 1);
      for (int i = 0; i < NUM_FLOWS; i++) credit_q[i] <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NUM_FLOWS; i++) credit_q[i] <= credit_d[i];
      if (take_grant) begin
        gnt_q       <= arb_gnt;
        gnt_id_q    <= arb_idx;
        gnt_valid_q <= 1'b1;
        rr_ptr_q    <= arb_idx;
      end else if ((state_q == ST_GRANT) && frame_done) begin
        gnt_q       <= '0;
        gnt_valid_q <= 1'b0;
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
      if (frame_done && (state_q != ST_GRANT)) proto_err_q <= 1'b1;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign frame_cnt = frame_cnt_q;
  assign proto_err = proto_err_q;
  assign dbg_state = state_q;

endmodule
